reply_tx: RTL and testbench
===========================

# reply_tx

Serial transmitter for the return link: sends a short reply word (default 8 bits: 7-bit board cell index plus pass flag) from the board-receiving side back to the board-sending side. It is the reverse-direction counterpart of the 162-bit forward serial link. It shares that link's clocking, reset and trigger-style launch. A frame starts on a rising edge of `trigger_in`, and a one-deep pending buffer accepts a second launch while a frame is in flight.

## Interface
- `WIDTH`, default 8, payload bits per frame (1..32).
- `CYCLES_PER_BIT`, default 1000, clock cycles per line bit (≥2).
- `GUARD_BITS`, default 2, idle-high bit periods forced after each stop bit (≥0).

- `clk_in`  input  1  system clock.
- `rst_in`  input  1  asynchronous, active-high reset.
- `trigger_in`  input  1  launch request; level signal, rising edge is the event.
- `val_in`  input  WIDTH  payload, sampled on the launch edge.
- `data_out`  output  1  serial line; idles high.
- `busy`  output  1  high while a frame or guard interval is in progress.
- `done`  output  1  one-cycle pulse when a stop bit completes.
- `overflow`  output  1  one-cycle pulse when a launch edge is dropped.

## Operation
- Frame layout: start bit (0), then WIDTH data bits LSB first, then the optional parity bit, then a stop bit (1).
- After the stop bit, the line is held high for GUARD_BITS periods.
- Edge detect uses registered `trig_q`. An event occurs when `trigger_in`=1 and `trig_q`=0. `trig_q` resets to 1, so a trigger held high through reset does not launch.
- States:
  - IDLE: on an event, `val_in` is loaded into the shift register and the state goes to START.
  - START: after CYCLES_PER_BIT cycles, go to DATA.
  - DATA: WIDTH bit periods, shifting right each period. Then go to PARITY if enabled, else STOP.
  - PARITY: one bit period, then STOP.
  - STOP: one bit period. On exit, `done` pulses and the state goes to GUARD, or to IDLE if GUARD_BITS=0.
  - GUARD: GUARD_BITS bit periods, then go to IDLE.
- Pending buffer:
  - An event outside IDLE stores `val_in` into `pend_data` and sets `pend_valid`.
  - An event while `pend_valid`=1 is dropped, pulses `overflow`, and leaves the existing pending data unchanged.
  - On the cycle that would return to IDLE, if `pend_valid`=1, the block loads `pend_data`, clears `pend_valid` and enters START directly.
- Bit counter: a 16-bit cycle counter plus a $clog2(WIDTH+1)-bit data bit counter. The cycle counter wraps to 0 at CYCLES_PER_BIT-1.
- Simultaneous cases:
  - An event in the same cycle as a return to IDLE with `pend_valid`=0 launches immediately.
  - With `pend_valid`=1 in that same cycle, the pending word launches and the new event is stored into pending.
- Reset at any time, including mid-frame:
  - State returns to IDLE and the line goes high immediately (asynchronous).
  - Pending contents are discarded.

## Timing
- Reset values:
  - `data_out`=1, `busy`=0, `done`=0, `overflow`=0.
  - State IDLE, `pend_valid`=0, `trig_q`=1.
- Launch latency: the event is seen at clock edge N. At edge N, `data_out` goes to 0 and `busy` goes to 1, with all outputs registered.
- Each bit lasts exactly CYCLES_PER_BIT cycles.
- Frame length F = (WIDTH+2+P)·CYCLES_PER_BIT cycles, where P=1 with parity and 0 without.
- `done` is high in the single cycle after the last stop-bit cycle, i.e. at edge N+F.
- `busy` falls at edge N+F+GUARD_BITS·CYCLES_PER_BIT if nothing is pending. With a pending word, `busy` stays high continuously.
- Back-to-back frames are separated by exactly GUARD_BITS periods of high.
- `val_in` is only sampled at the event edge. Later changes have no effect on the frame in flight.

## Configuration
- `REPLY_TX_PARITY_EN` defined:
  - A PARITY bit is inserted after the data bits.
  - Its value is the even parity of the payload (XOR of all WIDTH bits), so the total count of 1s in data+parity is even.
- `REPLY_TX_PARITY_EN` undefined:
  - No PARITY state; P=0 and STOP follows DATA directly.
  - The frame is one bit period shorter.

## Test plan
Bench parameters: WIDTH=8, CYCLES_PER_BIT=4, GUARD_BITS=2, parity enabled, unless noted.
- Single frame: rising edge with `val_in`=8'hA5.
  - Line sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1, parity 0, stop 1.
  - `done` pulses 44 cycles after launch; `busy` falls 52 cycles after launch.
- Level hold: `trigger_in` held high for 200 cycles with 8'h01 → exactly one frame; the parity bit is 1.
- Pending: launch 8'h3C, then a second edge with 8'hC3 during DATA.
  - The second frame's start bit begins exactly 8 cycles after the first stop bit ends.
  - `busy` stays high throughout; two `done` pulses.
- Overflow: three edges within one frame.
  - `overflow` pulses once on the third edge.
  - Only the first two words are transmitted, in order.
- Reset mid-frame: assert `rst_in` during DATA.
  - `data_out`=1 and `busy`=0 immediately.
  - No `done` pulse; the pending word is discarded.
  - `trigger_in` held high through the reset release does not launch a frame.
- Parity disabled build: 8'hA5 → 40-cycle frame with the stop bit directly after data bit 7.

Source files
------------

// File: rtl/reply_tx.sv
// reply_tx: return-link serial transmitter (start, WIDTH data bits LSB first,
// optional even parity under `REPLY_TX_PARITY_EN, stop, guard) with one-deep launch buffer.
module reply_tx #(
    parameter int WIDTH          = 8,
    parameter int CYCLES_PER_BIT = 1000,
    parameter int GUARD_BITS     = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             trigger_in,
    input  logic [WIDTH-1:0] val_in,
    output logic             data_out,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int GCW = (GUARD_BITS > 0) ? $clog2(GUARD_BITS + 1) : 1;
    localparam logic [15:0]    CPB_LAST   = 16'(CYCLES_PER_BIT - 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(WIDTH - 1);
    localparam logic [GCW-1:0] GUARD_LAST = GCW'((GUARD_BITS > 0) ? GUARD_BITS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GUARD  = 3'd5
    } state_t;

    state_t           state_r;
    logic [15:0]      cyc_cnt_r;
    logic [BCW-1:0]   bit_cnt_r;
    logic [GCW-1:0]   guard_cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] pend_data_r;
    logic             pend_valid_r;
    logic             trig_q_r;
`ifdef REPLY_TX_PARITY_EN
    logic             par_r;
`endif

    logic             event_s;
    logic             bit_end_s;
    logic             idle_ret_s;
    logic             launch_s;
    logic [WIDTH-1:0] launch_word_s;
    logic [WIDTH-1:0] shift_nx_s;
    logic             pend_valid_nx_s;
    logic [WIDTH-1:0] pend_data_nx_s;
    logic             overflow_s;

`ifdef REPLY_TX_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction
`endif

    // Launch arbitration: IDLE or a return-to-IDLE cycle serves pending first, then a fresh event.
    always_comb begin
        event_s         = trigger_in && !trig_q_r;
        bit_end_s       = (cyc_cnt_r == CPB_LAST);
        shift_nx_s      = shift_r >> 1;
        launch_s        = 1'b0;
        launch_word_s   = val_in;
        pend_valid_nx_s = pend_valid_r;
        pend_data_nx_s  = pend_data_r;
        overflow_s      = 1'b0;
        idle_ret_s      = 1'b0;
        if (bit_end_s && state_r == S_STOP && GUARD_BITS == 0) begin
            idle_ret_s = 1'b1;
        end else if (bit_end_s && state_r == S_GUARD && guard_cnt_r == GUARD_LAST) begin
            idle_ret_s = 1'b1;
        end else begin
            idle_ret_s = 1'b0;
        end
        if (state_r == S_IDLE || idle_ret_s) begin
            if (pend_valid_r) begin
                launch_s      = 1'b1;
                launch_word_s = pend_data_r;
                if (event_s) begin
                    pend_valid_nx_s = 1'b1;
                    pend_data_nx_s  = val_in;
                end else begin
                    pend_valid_nx_s = 1'b0;
                end
            end else if (event_s) begin
                launch_s      = 1'b1;
                launch_word_s = val_in;
            end else begin
                launch_s = 1'b0;
            end
        end else if (event_s) begin
            if (pend_valid_r) begin
                overflow_s = 1'b1;
            end else begin
                pend_valid_nx_s = 1'b1;
                pend_data_nx_s  = val_in;
            end
        end else begin
            overflow_s = 1'b0;
        end
    end

    // Frame FSM with registered line and status outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r      <= S_IDLE;
            cyc_cnt_r    <= 16'd0;
            bit_cnt_r    <= '0;
            guard_cnt_r  <= '0;
            shift_r      <= '0;
            pend_data_r  <= '0;
            pend_valid_r <= 1'b0;
            trig_q_r     <= 1'b1;
`ifdef REPLY_TX_PARITY_EN
            par_r        <= 1'b0;
`endif
            data_out     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            trig_q_r     <= trigger_in;
            pend_valid_r <= pend_valid_nx_s;
            pend_data_r  <= pend_data_nx_s;
            overflow     <= overflow_s;
            done         <= (state_r == S_STOP) && bit_end_s;
            if (launch_s) begin
                state_r   <= S_START;
                shift_r   <= launch_word_s;
`ifdef REPLY_TX_PARITY_EN
                par_r     <= even_parity(launch_word_s);
`endif
                cyc_cnt_r <= 16'd0;
                bit_cnt_r <= '0;
                data_out  <= 1'b0;
                busy      <= 1'b1;
            end else begin
                cyc_cnt_r <= bit_end_s ? 16'd0 : cyc_cnt_r + 16'd1;
                case (state_r)
                    S_IDLE: begin
                        cyc_cnt_r <= 16'd0;
                        data_out  <= 1'b1;
                        busy      <= 1'b0;
                    end
                    S_START: begin
                        if (bit_end_s) begin
                            state_r  <= S_DATA;
                            data_out <= shift_r[0];
                        end
                    end
                    S_DATA: begin
                        if (bit_end_s && bit_cnt_r == BIT_LAST) begin
`ifdef REPLY_TX_PARITY_EN
                            state_r  <= S_PARITY;
                            data_out <= par_r;
`else
                            state_r  <= S_STOP;
                            data_out <= 1'b1;
`endif
                        end else if (bit_end_s) begin
                            bit_cnt_r <= bit_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
                            shift_r   <= shift_nx_s;
                            data_out  <= shift_nx_s[0];
                        end
                    end
                    S_PARITY: begin
                        if (bit_end_s) begin
                            state_r  <= S_STOP;
                            data_out <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        data_out <= 1'b1;
                        if (bit_end_s) begin
                            if (GUARD_BITS == 0) begin
                                state_r <= S_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                state_r     <= S_GUARD;
                                guard_cnt_r <= '0;
                            end
                        end
                    end
                    S_GUARD: begin
                        data_out <= 1'b1;
                        if (bit_end_s && guard_cnt_r == GUARD_LAST) begin
                            state_r <= S_IDLE;
                            busy    <= 1'b0;
                        end else if (bit_end_s) begin
                            guard_cnt_r <= guard_cnt_r + {{(GCW-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state_r  <= S_IDLE;
                        data_out <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reply_tx.sv
// Directed self-checking bench for reply_tx (WIDTH=8, CYCLES_PER_BIT=4, GUARD_BITS=2);
// frame length follows whether REPLY_TX_PARITY_EN is defined.
module tb_reply_tx;

    localparam int CPB = 4;
`ifdef REPLY_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 10 + P;
    localparam int F     = NBITS * CPB;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       trigger_in = 1'b0;
    logic [7:0] val_in = 8'h00;
    logic       data_out;
    logic       busy;
    logic       done;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    reply_tx #(.WIDTH(8), .CYCLES_PER_BIT(CPB), .GUARD_BITS(2)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .trigger_in(trigger_in),
        .val_in    (val_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit period i of a frame carrying v.
    function automatic logic frame_bit(input logic [7:0] v, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return v[i-1];
        if (P == 1 && i == 9) return ^v;
        return 1'b1;
    endfunction

    // Called just after the launch edge; ends just after the edge that raises done.
    task automatic expect_frame(input logic [7:0] v, input int k1, input logic [7:0] v1,
                                input int k2, input logic [7:0] v2, input bit hold);
        for (int k = 0; k < F; k++) begin
            check("line", 32'(data_out), 32'(frame_bit(v, k / CPB)));
            check("busy_frame", 32'(busy), 32'd1);
            check("done_low", 32'(done), 32'd0);
            check("overflow", 32'(overflow), 32'((k2 >= 0) && (k == k2 + 1)));
            if (!hold && k == 0) begin
                trigger_in = 1'b0;
                val_in     = ~v;
            end
            if (k1 >= 0 && k == k1) begin
                trigger_in = 1'b1;
                val_in     = v1;
            end
            if (k1 >= 0 && k == k1 + 2) trigger_in = 1'b0;
            if (k2 >= 0 && k == k2) begin
                trigger_in = 1'b1;
                val_in     = v2;
            end
            if (k2 >= 0 && k == k2 + 2) trigger_in = 1'b0;
            step();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("stop_line", 32'(data_out), 32'd1);
        check("busy_at_done", 32'(busy), 32'd1);
    endtask

    // Guard interval after done; with a pending word the next launch edge is the 8th step.
    task automatic expect_guard(input bit pending);
        for (int i = 1; i < 2 * CPB; i++) begin
            step();
            check("guard_busy", 32'(busy), 32'd1);
            check("guard_line", 32'(data_out), 32'd1);
            check("guard_done", 32'(done), 32'd0);
        end
        step();
        if (!pending) begin
            check("busy_fall", 32'(busy), 32'd0);
            check("idle_line", 32'(data_out), 32'd1);
        end
    endtask

    initial begin
        // Reset values
        step();
        check("rst_line", 32'(data_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_in = 1'b0;
        step();
        step();

        // Single frame A5
        val_in = 8'hA5;
        trigger_in = 1'b1;
        step();
        expect_frame(8'hA5, -1, 8'h00, -1, 8'h00, 1'b0);
        expect_guard(1'b0);
        step();

        // Level hold: one frame only, parity bit 1 for 8'h01
        val_in = 8'h01;
        trigger_in = 1'b1;
        step();
        expect_frame(8'h01, -1, 8'h00, -1, 8'h00, 1'b1);
        expect_guard(1'b0);
        for (int i = 0; i < 140; i++) begin
            step();
            check("hold_no_relaunch", 32'(busy), 32'd0);
        end
        trigger_in = 1'b0;
        step();
        step();

        // Pending: 3C then C3 queued during DATA
        val_in = 8'h3C;
        trigger_in = 1'b1;
        step();
        expect_frame(8'h3C, 10, 8'hC3, -1, 8'h00, 1'b0);
        expect_guard(1'b1);
        expect_frame(8'hC3, -1, 8'h00, -1, 8'h00, 1'b0);
        expect_guard(1'b0);
        step();

        // Overflow: third edge dropped, pending keeps 22
        val_in = 8'h11;
        trigger_in = 1'b1;
        step();
        expect_frame(8'h11, 6, 8'h22, 14, 8'h33, 1'b0);
        expect_guard(1'b1);
        expect_frame(8'h22, -1, 8'h00, -1, 8'h00, 1'b0);
        expect_guard(1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("no_third_frame", 32'(busy), 32'd0);
        end

        // Reset mid-frame with a pending word and trigger held through release
        val_in = 8'h5A;
        trigger_in = 1'b1;
        step();
        check("rst_test_launch", 32'(busy), 32'd1);
        trigger_in = 1'b0;
        for (int i = 0; i < 5; i++) step();
        val_in = 8'h77;
        trigger_in = 1'b1;
        step();
        step();
        #2;
        rst_in = 1'b1;
        #1;
        check("async_rst_line", 32'(data_out), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        step();
        step();
        rst_in = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_line", 32'(data_out), 32'd1);
            check("post_rst_done", 32'(done), 32'd0);
        end
        trigger_in = 1'b0;
        step();
        check("post_rst_idle", 32'(busy), 32'd0);

        // Recovery after reset
        val_in = 8'h81;
        trigger_in = 1'b1;
        step();
        expect_frame(8'h81, -1, 8'h00, -1, 8'h00, 1'b0);
        expect_guard(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
